// File: rtl/part_scanmux_reg.sv
// ---------------------------------------------------------------------------
// part_scanmux_reg
//
// Registered N-channel multiplexer with a direct-select mode and an
// auto-scan mode. Every capture (LD high on a rising CLK edge) loads one
// channel of D into Y. An active-low strobe ENB_N forces the captured data
// to zero, in the manner of a 74S157.
//
// Parameters
//   WIDTH     bits per channel (1..32)
//   CHANNELS  number of input channels (2..8)
//   SELW      width of SEL / CH; 2**SELW must cover CHANNELS
//
// Ports
//   CLK      in   rising-edge clock
//   RESET_N  in   asynchronous active-low reset
//   D        in   flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   SEL      in   channel select used in direct mode
//   ENB_N    in   active-low strobe; high captures zero
//   MODE     in   0 = direct select, 1 = auto-scan
//   LD       in   capture strobe
//   Y        out  registered mux output
//   CH       out  index of the channel held in Y
//   VALID    out  Y holds a captured value
//   WRAP     out  one-cycle pulse after the scan captured the last channel
//   ERR      out  sticky: a direct capture used an out-of-range SEL
// ---------------------------------------------------------------------------
module part_scanmux_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int SELW     = 3
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [WIDTH*CHANNELS-1:0] D,
  input  logic [SELW-1:0]           SEL,
  input  logic                      ENB_N,
  input  logic                      MODE,
  input  logic                      LD,
  output logic [WIDTH-1:0]          Y,
  output logic [SELW-1:0]           CH,
  output logic                      VALID,
  output logic                      WRAP,
  output logic                      ERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [SELW-1:0] LAST_CH   = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   CHAN_EXT  = (SELW+1)'(CHANNELS);

  state_t            state, state_nxt;
  logic [SELW-1:0]   scnt, scnt_nxt;
  logic [WIDTH-1:0]  y_nxt;
  logic [SELW-1:0]   ch_nxt;
  logic              valid_nxt, wrap_nxt, err_nxt;

  logic [SELW-1:0]   scan_idx;
  logic              sel_bad;
  logic [WIDTH-1:0]  direct_data, scan_data;

  // Channel lookup; indices outside the channel range return zero.
  function automatic logic [WIDTH-1:0] channel_data(
    input logic [WIDTH*CHANNELS-1:0] din,
    input logic [SELW-1:0]           idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) r = din[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Any capture that does not continue an ongoing scan starts at channel 0,
  // so IDLE and DIRECT both restart the scan position.
  assign scan_idx    = (state == SCAN) ? scnt : '0;
  assign sel_bad     = ({1'b0, SEL} >= CHAN_EXT);
  assign direct_data = channel_data(D, SEL);
  assign scan_data   = channel_data(D, scan_idx);

  // Next-state and next-output logic. Without LD everything holds except
  // WRAP, which is a single-cycle pulse.
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    y_nxt     = Y;
    ch_nxt    = CH;
    valid_nxt = VALID;
    wrap_nxt  = 1'b0;
    err_nxt   = ERR;

    if (LD) begin
      valid_nxt = 1'b1;
      if (!MODE) begin
        state_nxt = DIRECT;
        ch_nxt    = SEL;
        scnt_nxt  = '0;
        if (sel_bad) begin
          y_nxt   = '0;
          err_nxt = 1'b1;
        end else begin
          y_nxt = ENB_N ? '0 : direct_data;
        end
      end else begin
        state_nxt = SCAN;
        ch_nxt    = scan_idx;
        y_nxt     = ENB_N ? '0 : scan_data;
        wrap_nxt  = (scan_idx == LAST_CH);
        scnt_nxt  = (scan_idx == LAST_CH) ? '0 : scan_idx + SELW'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously by RESET_N.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      scnt  <= '0;
      Y     <= '0;
      CH    <= '0;
      VALID <= 1'b0;
      WRAP  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      Y     <= y_nxt;
      CH    <= ch_nxt;
      VALID <= valid_nxt;
      WRAP  <= wrap_nxt;
      ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_part_scanmux_reg.sv
// ---------------------------------------------------------------------------
// tb_part_scanmux_reg
//
// Directed bench for part_scanmux_reg. Two instances share clock, reset and
// control inputs: a 2-channel one for direct select / strobe / error cases
// and a 4-channel one for the scan sequence, hold, restart and reset cases.
// ---------------------------------------------------------------------------
module tb_part_scanmux_reg;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic        enb_n;
  logic        mode;
  logic        ld;

  logic [7:0]  d2;
  logic [3:0]  y2;
  logic [2:0]  ch2;
  logic        valid2, wrap2, err2;

  logic [15:0] d4;
  logic [3:0]  y4;
  logic [2:0]  ch4;
  logic        valid4, wrap4, err4;

  int checks   = 0;
  int failures = 0;

  part_scanmux_reg #(.WIDTH(4), .CHANNELS(2), .SELW(3)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .D(d2), .SEL(sel), .ENB_N(enb_n),
    .MODE(mode), .LD(ld), .Y(y2), .CH(ch2), .VALID(valid2),
    .WRAP(wrap2), .ERR(err2)
  );

  part_scanmux_reg #(.WIDTH(4), .CHANNELS(4), .SELW(3)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .D(d4), .SEL(sel), .ENB_N(enb_n),
    .MODE(mode), .LD(ld), .Y(y4), .CH(ch4), .VALID(valid4),
    .WRAP(wrap4), .ERR(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advances one rising edge and settles past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset low between clock edges and confirms the outputs of the
  // selected instance clear without any edge.
  task automatic resetPulse(input bit chk2, input bit chk4);
    rst_n = 1'b0;
    #1;
    if (chk2) begin
      checkOutput("rst2_y", 32'(y2), 32'h0);
      checkOutput("rst2_ch", 32'(ch2), 32'h0);
      checkOutput("rst2_valid", 32'(valid2), 32'h0);
      checkOutput("rst2_wrap", 32'(wrap2), 32'h0);
      checkOutput("rst2_err", 32'(err2), 32'h0);
    end
    if (chk4) begin
      checkOutput("rst4_y", 32'(y4), 32'h0);
      checkOutput("rst4_ch", 32'(ch4), 32'h0);
      checkOutput("rst4_valid", 32'(valid4), 32'h0);
      checkOutput("rst4_wrap", 32'(wrap4), 32'h0);
    end
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] scan_y  [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
  logic [2:0] scan_ch [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
  logic       scan_w  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    sel   = 3'd0;
    enb_n = 1'b0;
    mode  = 1'b0;
    ld    = 1'b0;
    d2    = {4'hA, 4'h5};
    d4    = {4'h4, 4'h3, 4'h2, 4'h1};

    applyStimulus();
    applyStimulus();
    checkOutput("init_y", 32'(y2), 32'h0);
    checkOutput("init_valid", 32'(valid2), 32'h0);
    rst_n = 1'b1;
    applyStimulus();

    // Direct select
    sel = 3'd1; ld = 1'b1;
    applyStimulus();
    checkOutput("dir1_y", 32'(y2), 32'hA);
    checkOutput("dir1_ch", 32'(ch2), 32'h1);
    checkOutput("dir1_valid", 32'(valid2), 32'h1);
    checkOutput("dir1_wrap", 32'(wrap2), 32'h0);
    sel = 3'd0;
    applyStimulus();
    checkOutput("dir0_y", 32'(y2), 32'h5);
    checkOutput("dir0_ch", 32'(ch2), 32'h0);

    // Asynchronous reset between edges
    ld = 1'b0;
    resetPulse(1'b1, 1'b0);
    applyStimulus();

    // Strobe and error
    enb_n = 1'b1; sel = 3'd0; ld = 1'b1;
    applyStimulus();
    checkOutput("strb_y", 32'(y2), 32'h0);
    checkOutput("strb_valid", 32'(valid2), 32'h1);
    checkOutput("strb_err", 32'(err2), 32'h0);
    enb_n = 1'b0; sel = 3'd3;
    applyStimulus();
    checkOutput("err_y", 32'(y2), 32'h0);
    checkOutput("err_ch", 32'(ch2), 32'h3);
    checkOutput("err_set", 32'(err2), 32'h1);
    sel = 3'd1;
    applyStimulus();
    checkOutput("err_y2", 32'(y2), 32'hA);
    checkOutput("err_sticky", 32'(err2), 32'h1);

    // MODE / ENB_N changes without LD have no effect
    ld = 1'b0; mode = 1'b1; enb_n = 1'b1; sel = 3'd0;
    applyStimulus();
    checkOutput("noLd_y", 32'(y2), 32'hA);
    checkOutput("noLd_ch", 32'(ch2), 32'h1);

    // Scan wrap on the 4-channel instance
    mode = 1'b0; enb_n = 1'b0;
    resetPulse(1'b0, 1'b1);
    applyStimulus();
    mode = 1'b1; ld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput($sformatf("scan%0d_y", i), 32'(y4), 32'(scan_y[i]));
      checkOutput($sformatf("scan%0d_ch", i), 32'(ch4), 32'(scan_ch[i]));
      checkOutput($sformatf("scan%0d_wrap", i), 32'(wrap4), 32'(scan_w[i]));
    end
    checkOutput("scan_err", 32'(err4), 32'h0);

    // Hold: LD low for three cycles, then the scan resumes at channel 2
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold%0d_y", i), 32'(y4), 32'h2);
      checkOutput($sformatf("hold%0d_ch", i), 32'(ch4), 32'h1);
    end
    ld = 1'b1;
    applyStimulus();
    checkOutput("resume_y", 32'(y4), 32'h3);
    checkOutput("resume_ch", 32'(ch4), 32'h2);

    // One direct capture, then scan restarts at channel 0
    mode = 1'b0; sel = 3'd3;
    applyStimulus();
    checkOutput("mid_dir_y", 32'(y4), 32'h4);
    checkOutput("mid_dir_ch", 32'(ch4), 32'h3);
    checkOutput("mid_dir_wrap", 32'(wrap4), 32'h0);
    mode = 1'b1; sel = 3'd2;
    applyStimulus();
    checkOutput("restart_y", 32'(y4), 32'h1);
    checkOutput("restart_ch", 32'(ch4), 32'h0);
    applyStimulus();
    checkOutput("restart2_ch", 32'(ch4), 32'h1);
    applyStimulus();
    checkOutput("restart3_ch", 32'(ch4), 32'h2);

    // Reset mid-scan after capturing channel 2
    ld = 1'b0;
    resetPulse(1'b0, 1'b1);
    applyStimulus();
    ld = 1'b1;
    applyStimulus();
    checkOutput("postrst_ch", 32'(ch4), 32'h0);
    checkOutput("postrst_y", 32'(y4), 32'h1);
    checkOutput("postrst_wrap", 32'(wrap4), 32'h0);

    // Strobe high in scan still advances and can raise WRAP
    enb_n = 1'b1;
    applyStimulus();
    checkOutput("strbscan1_y", 32'(y4), 32'h0);
    checkOutput("strbscan1_ch", 32'(ch4), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("strbscan3_ch", 32'(ch4), 32'h3);
    checkOutput("strbscan3_wrap", 32'(wrap4), 32'h1);
    checkOutput("strbscan3_valid", 32'(valid4), 32'h1);
    ld = 1'b0;
    applyStimulus();
    checkOutput("wrap_clear", 32'(wrap4), 32'h0);
    checkOutput("scan_noerr", 32'(err4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
